// File: rtl/sdhc_ddr_bridge_read_master.sv
// Pipelined Avalon-MM read master feeding a valid/ready stream, with credit-limited issue.
// Optional abort/flush support is compiled in with `define SDHC_RDM_ABORT_EN.
module sdhc_ddr_bridge_read_master #(
  parameter int ADDR_W      = 23,
  parameter int LEN_W       = 16,
  parameter int FIFO_DEPTH  = 16,
  parameter int MAX_PENDING = 8
) (
  input  logic              slave_clk,
  input  logic              slave_reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_address,
  input  logic [LEN_W-1:0]  cmd_length,
  output logic [ADDR_W-1:0] avm_address,
  output logic [7:0]        avm_byteenable,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [63:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  output logic [63:0]       st_data,
  output logic              st_valid,
  input  logic              st_ready,
  output logic              st_last,
`ifdef SDHC_RDM_ABORT_EN
  input  logic              abort,
`endif
  output logic              busy,
  output logic              done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0]   LP_DEPTH = (CW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] LP_MAXP  = CW'(MAX_PENDING);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_remaining, r_length, r_rx_count;
  logic [CW-1:0]     r_pending, r_used, w_pending_nxt, w_used_nxt;
  logic [AW-1:0]     r_wptr, r_rptr;
  logic [63:0]       r_mem [FIFO_DEPTH];
  logic              r_hold, r_done, w_done_nxt;
  logic              w_cmd_acc, w_credit_ok, w_avm_read, w_rd_acc;
  logic              w_push, w_pop, w_st_valid;
  logic              w_abort_req, w_abort_active, w_aborting;

`ifdef SDHC_RDM_ABORT_EN
  logic r_abort;

  assign w_abort_req    = abort && (r_state != S_IDLE);
  assign w_abort_active = r_abort;

  always_ff @(posedge slave_clk or negedge slave_reset_n) begin
    if (!slave_reset_n)             r_abort <= 1'b0;
    else if (w_state_nxt == S_IDLE) r_abort <= 1'b0;
    else if (w_abort_req)           r_abort <= 1'b1;
  end
`else
  assign w_abort_req    = 1'b0;
  assign w_abort_active = 1'b0;
`endif

  assign w_aborting  = w_abort_req || w_abort_active;
  assign w_cmd_acc   = cmd_valid && (r_state == S_IDLE);
  assign w_credit_ok = (({1'b0, r_pending} + {1'b0, r_used}) < LP_DEPTH) && (r_pending < LP_MAXP);
  // r_hold keeps a stalled request asserted even if abort would otherwise withdraw it
  assign w_avm_read  = r_hold ||
                       ((r_state == S_ISSUE) && (r_remaining != '0) && w_credit_ok && !w_aborting);
  assign w_rd_acc    = w_avm_read && !avm_waitrequest;
  assign w_push      = avm_readdatavalid && !w_aborting;
  assign w_st_valid  = (r_used != '0) && !w_abort_active;
  assign w_pop       = w_st_valid && st_ready;

  assign w_pending_nxt = r_pending + CW'(w_rd_acc) - CW'(avm_readdatavalid);
  assign w_used_nxt    = r_used + CW'(w_push) - CW'(w_pop);

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_cmd_acc) begin
          if (cmd_length == '0) w_done_nxt  = 1'b1;
          else                  w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE, S_DRAIN: begin
        if (w_aborting) begin
          if ((r_pending == '0) && !w_avm_read) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end
        end else if (r_state == S_ISSUE) begin
          if (w_rd_acc && (r_remaining == LEN_W'(1))) w_state_nxt = S_DRAIN;
        end else if ((w_pending_nxt == '0) && (w_used_nxt == '0)) begin
          // exit on the cycle the last beat leaves so done lands one cycle later
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge slave_clk or negedge slave_reset_n) begin
    if (!slave_reset_n) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_length    <= '0;
      r_rx_count  <= '0;
      r_pending   <= '0;
      r_hold      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_done    <= w_done_nxt;
      r_hold    <= w_avm_read && avm_waitrequest;
      r_pending <= w_pending_nxt;
      if (w_cmd_acc) begin
        r_addr      <= cmd_address;
        r_remaining <= cmd_length;
        r_length    <= cmd_length;
        r_rx_count  <= '0;
      end else begin
        if (w_rd_acc) r_addr <= r_addr + ADDR_W'(1);
        if (w_abort_req)   r_remaining <= '0;
        else if (w_rd_acc) r_remaining <= r_remaining - LEN_W'(1);
        if (w_pop) r_rx_count <= r_rx_count + LEN_W'(1);
      end
    end
  end

  always_ff @(posedge slave_clk or negedge slave_reset_n) begin
    if (!slave_reset_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_used <= '0;
    end else if (w_aborting) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_used <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_used <= w_used_nxt;
    end
  end

  always_ff @(posedge slave_clk) begin
    if (w_push) r_mem[r_wptr] <= avm_readdata;
  end

  assign cmd_ready      = (r_state == S_IDLE);
  assign busy           = (r_state != S_IDLE);
  assign done           = r_done;
  assign avm_address    = r_addr;
  assign avm_read       = w_avm_read;
  assign avm_byteenable = '1;
  assign st_data        = r_mem[r_rptr];
  assign st_valid       = w_st_valid;
  assign st_last        = w_st_valid && (r_rx_count == (r_length - LEN_W'(1)));

endmodule
